// File: rtl/mem_bus_pkg.sv
// Shared definitions for the memory-bus initiator: default widths, the
// timeout default and the controller state encoding.
package mem_bus_pkg;

    localparam int ADDR_W_DEF  = 8;
    localparam int DATA_W_DEF  = 32;
    localparam int TIMEOUT_DEF = 15;

    // Width of the WAIT cycle counter; TIMEOUT is limited to 1..255.
    localparam int CNT_W = 8;

    // Bus cycle phases. SETUP gives address/data a full settle cycle
    // before the Start edge, and TURN gives the memory its data-hold cycle.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_STROBE  = 3'd2,
        ST_WAIT_LO = 3'd3,
        ST_WAIT_HI = 3'd4,
        ST_DONE    = 3'd5,
        ST_TURN    = 3'd6
    } state_t;

    // True while the controller is waiting on the memory handshake.
    function automatic logic is_wait(input state_t s);
        return (s == ST_WAIT_LO) || (s == ST_WAIT_HI);
    endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Counts consecutive WAIT cycles and flags the cycle on which the
// LIMIT-th one is being spent, so the controller can abort on that edge.
module mem_timeout_ctr
    import mem_bus_pkg::*;
#(
    parameter int LIMIT = TIMEOUT_DEF
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] r_count;
    logic             w_at_last;

    // r_count holds the number of WAIT cycles already completed.
    assign w_at_last = (r_count == LAST);
    assign o_expired = i_enable && w_at_last;

    // Cycle counter: cleared outside WAIT, saturates at LAST so it never wraps.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        // NOTE: clocked state is always updated with <= so every register
        // samples pre-edge values regardless of block ordering.
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !w_at_last) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/mem_initiator.sv
// Single-request memory bus initiator. Accepts one CPU request in IDLE,
// runs a Start/MemDone handshake on a shared tristate data bus, and returns
// a one-cycle completion pulse with read data or a timeout error.
module mem_initiator
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              Clock,
    input  logic              ResetN,
    input  logic              ReqValid,
    input  logic              ReqWrite,
    input  logic [ADDR_W-1:0] ReqAddr,
    input  logic [DATA_W-1:0] ReqWData,
    output logic              ReqReady,
    output logic              RspValid,
    output logic [DATA_W-1:0] RspData,
    output logic              RspError,
    output logic [ADDR_W-1:0] Address,
    output logic              Write,
    output logic              Start,
    inout  wire  [DATA_W-1:0] DataIO,
    input  logic              MemDone
);

    state_t            r_state;
    logic              r_req_ready;
    logic              r_rsp_valid;
    logic              r_rsp_error;
    logic [DATA_W-1:0] r_rsp_data;
    logic [ADDR_W-1:0] r_addr;
    logic              r_write;
    logic [DATA_W-1:0] r_wdata;
    logic              r_start;
    logic              r_drive;

    logic              w_in_wait;
    logic              w_expired;

    assign w_in_wait = is_wait(r_state);

    mem_timeout_ctr #(
        .LIMIT (TIMEOUT)
    ) u_timeout (
        .i_clk     (Clock),
        .i_rst_n   (ResetN),
        .i_clear   (!w_in_wait),
        .i_enable  (w_in_wait),
        .o_expired (w_expired)
    );

    // The initiator only owns the bus for write data in SETUP and STROBE.
    assign DataIO   = r_drive ? r_wdata : {DATA_W{1'bz}};

    assign ReqReady = r_req_ready;
    assign RspValid = r_rsp_valid;
    assign RspData  = r_rsp_data;
    assign RspError = r_rsp_error;
    assign Address  = r_addr;
    assign Write    = r_write;
    assign Start    = r_start;

    // Bus-cycle controller with every output registered.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            r_state     <= ST_IDLE;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_error <= 1'b0;
            r_rsp_data  <= '0;
            r_addr      <= '0;
            r_write     <= 1'b0;
            r_wdata     <= '0;
            r_start     <= 1'b0;
            r_drive     <= 1'b0;
        end else begin
            // Completion flags are single-cycle; only the WAIT exits raise them.
            r_rsp_valid <= 1'b0;
            r_rsp_error <= 1'b0;

            unique case (r_state)
                ST_IDLE: begin
                    if (ReqValid) begin
                        r_addr      <= ReqAddr;
                        r_write     <= ReqWrite;
                        r_wdata     <= ReqWData;
                        r_drive     <= ReqWrite;
                        r_req_ready <= 1'b0;
                        r_state     <= ST_SETUP;
                    end
                end

                ST_SETUP: begin
                    r_start <= 1'b1;
                    r_state <= ST_STROBE;
                end

                ST_STROBE: begin
                    // The memory latches write data on the Start edge, so the
                    // bus can be released as WAIT begins.
                    r_drive <= 1'b0;
                    r_state <= ST_WAIT_LO;
                end

                ST_WAIT_LO: begin
                    // MemDone may still be high from the previous access, so a
                    // high level here is not a completion; no completion can
                    // happen here, so the timeout wins.
                    if (w_expired) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_error <= 1'b1;
                        r_state     <= ST_DONE;
                    end else if (!MemDone) begin
                        r_state <= ST_WAIT_HI;
                    end
                end

                ST_WAIT_HI: begin
                    // A completion on the last allowed cycle still counts.
                    if (MemDone) begin
                        if (!r_write) begin
                            r_rsp_data <= DataIO;
                        end
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end else if (w_expired) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_error <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    r_start <= 1'b0;
                    r_state <= ST_TURN;
                end

                ST_TURN: begin
                    r_req_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end

                default: begin
                    r_start     <= 1'b0;
                    r_drive     <= 1'b0;
                    r_req_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_initiator.md
MEM_INITIATOR -- requirements
Module: mem_initiator

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, memory address width.
REQ-002 SHALL have parameter DATA_W, default 32, memory data width.
REQ-003 SHALL have parameter TIMEOUT, default 15, maximum WAIT cycles before abort (1..255).
REQ-004 SHALL have port Clock, input, 1, single clock; all state changes on rising edge.
REQ-005 SHALL have port ResetN, input, 1; reset is asynchronous and active-low.
REQ-006 SHALL have port ReqValid, input, 1, CPU request present.
REQ-007 SHALL have port ReqWrite, input, 1, 1=write, 0=read.
REQ-008 SHALL have port ReqAddr, input, ADDR_W, request address.
REQ-009 SHALL have port ReqWData, input, DATA_W, write data.
REQ-010 SHALL have port ReqReady, output, 1, block idle and accepting requests.
REQ-011 SHALL have port RspValid, output, 1, one-cycle completion pulse.
REQ-012 SHALL have port RspData, output, DATA_W, read data; holds last value.
REQ-013 SHALL have port RspError, output, 1, qualifies RspValid; 1=timeout abort.
REQ-014 SHALL have port Address, output, ADDR_W, memory address.
REQ-015 SHALL have port Write, output, 1, memory write select.
REQ-016 SHALL have port Start, output, 1, memory command strobe; memory acts on its rising edge.
REQ-017 SHALL have port DataIO, inout, DATA_W, shared tristate data bus.
REQ-018 SHALL have port MemDone, input, 1, memory completion flag, synchronous to Clock.

Function
REQ-019 SHALL implement states IDLE, SETUP, STROBE, WAIT_LO, WAIT_HI, DONE, TURN.
REQ-020 SHALL accept a request on a cycle with ReqValid=1 and ReqReady=1; ReqReady=1 only in IDLE.
REQ-021 SHALL register ReqAddr/ReqWrite/ReqWData on acceptance into Address/Write/write-data register and enter SETUP.
REQ-022 SHALL hold Start=0 in SETUP so Address/Write/DataIO settle one full cycle before the Start edge.
REQ-023 SHALL drive Start=1 from STROBE entry until DONE exit, then Start=0.
REQ-024 SHALL drive DataIO with write data in SETUP and STROBE for writes only; DataIO=Z in every other state and for all reads.
REQ-025 SHALL go STROBE->WAIT_LO unconditionally after one cycle.
REQ-026 SHALL, in WAIT_LO, ignore MemDone=1 (stale idle-high level) and advance to WAIT_HI on the first cycle MemDone=0.
REQ-027 SHALL, in WAIT_HI, advance to DONE on the first cycle MemDone=1, capturing DataIO into RspData on that edge for reads.
REQ-028 SHALL leave RspData unchanged on writes and on timeout.
REQ-029 SHALL count cycles spent in WAIT_LO plus WAIT_HI; upon reaching TIMEOUT with no completion, go to DONE with RspError=1.
REQ-030 SHALL pulse RspValid=1 for exactly the one DONE cycle; RspError valid only then, 0 otherwise.
REQ-031 SHALL go DONE->TURN->IDLE; TURN is a one-cycle bus turnaround covering the memory's post-MemDone data hold.
REQ-032 SHALL yield minimum latency acceptance-to-RspValid of 5 cycles (SETUP, STROBE, WAIT_LO, WAIT_HI, DONE) and minimum request spacing of 7 cycles.
REQ-033 SHALL ignore ReqValid and all Req* inputs outside IDLE; no queuing.
REQ-034 SHALL keep Address and Write stable from SETUP through TURN.

Reset
REQ-035 SHALL, on ResetN=0 in any state, asynchronously force IDLE, Start=0, Write=0, Address=0, DataIO=Z, ReqReady=1, RspValid=0, RspError=0, RspData=0, timeout count=0.
REQ-036 SHALL not issue RspValid for a transaction interrupted by reset; first post-reset acceptance is the cycle after ResetN deasserts.

Structure
REQ-037 SHALL place the state enumeration, ADDR_W/DATA_W/TIMEOUT defaults and state encodings in shared package mem_bus_pkg.
REQ-038 SHALL implement the WAIT timeout as sub-module mem_timeout_ctr (clear, enable, expired output).

Verification
REQ-039 SHALL verify: write 0xDEADBEEF to 0x80 against the behavioural SRAM model -> RspValid at cycle 5, RspError=0, model mem[0x80]=0xDEADBEEF.
REQ-040 SHALL verify: read 0x00 with model preloaded 0x87888001 -> RspData=0x87888001, RspError=0, DataIO never driven by initiator.
REQ-041 SHALL verify: MemDone held 1 throughout -> no completion in WAIT_LO, RspValid with RspError=1 after 15 WAIT cycles, RspData unchanged.
REQ-042 SHALL verify: ResetN pulsed low in WAIT_HI -> Start=0, DataIO=Z immediately, no RspValid, ReqReady=1.
REQ-043 SHALL verify: ReqValid held high with three back-to-back requests (write 0x81=0x1, read 0x81, read 0x89) -> spacing 7 cycles, reads return 0x00000001 and model value, mid-transaction Req* changes ignored.
